byte_word_packer: RTL and testbench

- Downstream neighbour of the 8-bit valid/ready skid stage.
- Consumes its byte stream and packs BYTES_PER_WORD consecutive bytes into one wide word, little-endian.
- A per-byte last marker flushes a partial word early.
- The output word is registered (forward register slice), so down_valid/down_data come straight from flops.

---
 rtl/byte_word_packer.sv | 86 ++++++++
 tb/tb_byte_word_packer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/byte_word_packer.sv
// Packs a valid/ready byte stream into little-endian words of BYTES_PER_WORD bytes.
// A last marker flushes a partial word early. The output word is held in a forward register slice.
module byte_word_packer #(
  parameter int BYTES_PER_WORD = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [7:0]                  up_data,
  input  logic                        up_valid,
  input  logic                        up_last,
  output logic                        up_ready,
  output logic [8*BYTES_PER_WORD-1:0] down_data,
  output logic [BYTES_PER_WORD-1:0]   down_keep,
  output logic                        down_last,
  output logic                        down_valid,
  input  logic                        down_ready
);
  localparam int CNT_W = $clog2(BYTES_PER_WORD);

  logic [CNT_W-1:0]            r_cnt;
  logic [8*BYTES_PER_WORD-1:0] r_acc;
  logic [BYTES_PER_WORD-1:0]   r_kacc;
  logic [8*BYTES_PER_WORD-1:0] r_data;
  logic [BYTES_PER_WORD-1:0]   r_keep;
  logic                        r_last;
  logic                        r_valid;

  logic                        w_up_fire;
  logic                        w_down_fire;
  logic                        w_close;
  logic [8*BYTES_PER_WORD-1:0] w_acc_nxt;
  logic [BYTES_PER_WORD-1:0]   w_keep_nxt;

  // A stalled output word blocks input, so no partial word grows behind it.
  assign up_ready    = rst_n & (~r_valid | down_ready);
  assign w_up_fire   = up_valid & up_ready;
  assign w_down_fire = r_valid & down_ready;
  assign w_close     = (r_cnt == CNT_W'(BYTES_PER_WORD - 1)) | up_last;

  // Accumulator with the incoming byte merged into lane r_cnt.
  always_comb begin
    w_acc_nxt  = r_acc;
    w_keep_nxt = r_kacc;
    for (int i = 0; i < BYTES_PER_WORD; i++) begin
      if (r_cnt == CNT_W'(i)) begin
        w_acc_nxt[8*i +: 8] = up_data;
        w_keep_nxt[i]       = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_acc   <= '0;
      r_kacc  <= '0;
      r_data  <= '0;
      r_keep  <= '0;
      r_last  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      if (w_down_fire) r_valid <= 1'b0;
      if (w_up_fire) begin
        if (w_close) begin
          r_data  <= w_acc_nxt;
          r_keep  <= w_keep_nxt;
          r_last  <= up_last;
          r_valid <= 1'b1;
          r_cnt   <= '0;
          r_acc   <= '0;
          r_kacc  <= '0;
        end else begin
          r_acc   <= w_acc_nxt;
          r_kacc  <= w_keep_nxt;
          r_cnt   <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign down_data  = r_data;
  assign down_keep  = r_keep;
  assign down_last  = r_last;
  assign down_valid = r_valid;

endmodule

// File: tb/tb_byte_word_packer.sv
// Bench for byte_word_packer: directed scenarios, then random traffic, all checked
// against a packet-level model that collects accepted bytes in a queue.
module tb_byte_word_packer;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [7:0]     up_data;
  logic           up_valid;
  logic           up_last;
  logic           up_ready;
  logic [8*N-1:0] down_data;
  logic [N-1:0]   down_keep;
  logic           down_last;
  logic           down_valid;
  logic           down_ready;

  byte_word_packer #(.BYTES_PER_WORD(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .up_data(up_data), .up_valid(up_valid), .up_last(up_last), .up_ready(up_ready),
    .down_data(down_data), .down_keep(down_keep), .down_last(down_last),
    .down_valid(down_valid), .down_ready(down_ready)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Model: bytes of the word being built, plus the word currently offered downstream.
  logic [7:0]     cur[$];
  logic           m_valid;
  logic [8*N-1:0] m_data;
  logic [N-1:0]   m_keep;
  logic           m_last;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    cur.delete();
    m_valid = 1'b0;
    m_data  = '0;
    m_keep  = '0;
    m_last  = 1'b0;
  endtask

  task automatic model_edge();
    logic rdy;
    if (!rst_n) begin
      model_reset();
    end else begin
      rdy = !m_valid || down_ready;
      if (m_valid && down_ready) m_valid = 1'b0;
      if (up_valid && rdy) begin
        cur.push_back(up_data);
        if (cur.size() == N || up_last) begin
          m_data = '0;
          foreach (cur[i]) m_data[8*i +: 8] = cur[i];
          m_keep = N'((1 << cur.size()) - 1);
          m_last = up_last;
          m_valid = 1'b1;
          cur.delete();
        end
      end
    end
  endtask

  task automatic compare();
    chk("up_ready", 64'(up_ready), 64'(rst_n && (!m_valid || down_ready)));
    chk("down_valid", 64'(down_valid), 64'(m_valid));
    if (m_valid) begin
      chk("down_data", 64'(down_data), 64'(m_data));
      chk("down_keep", 64'(down_keep), 64'(m_keep));
      chk("down_last", 64'(down_last), 64'(m_last));
    end
  endtask

  // Inputs change at negedge; outputs are checked 1 time unit later, well before the next posedge.
  task automatic step(input logic v, input logic [7:0] d, input logic l,
                      input logic dr, input logic rs);
    up_valid = v; up_data = d; up_last = l; down_ready = dr; rst_n = rs;
    #1;
    compare();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] held;
    up_valid = 0; up_data = 0; up_last = 0; down_ready = 0; rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_valid", 64'(down_valid), 64'(0));
    chk("rst_data",  64'(down_data),  64'(0));
    chk("rst_keep",  64'(down_keep),  64'(0));
    chk("rst_last",  64'(down_last),  64'(0));
    chk("rst_ready", 64'(up_ready),   64'(0));
    @(negedge clk);

    // 1: full word
    step(1, 8'h11, 0, 1, 1); step(1, 8'h22, 0, 1, 1);
    step(1, 8'h33, 0, 1, 1); step(1, 8'h44, 0, 1, 1);
    chk("t1_data", 64'(down_data), 64'h44332211);
    chk("t1_keep", 64'(down_keep), 64'hF);
    chk("t1_last", 64'(down_last), 64'h0);

    // 2: early flush, then next byte lands in lane 0
    step(1, 8'hA1, 0, 1, 1); step(1, 8'hA2, 1, 1, 1);
    chk("t2_data", 64'(down_data), 64'h0000A2A1);
    chk("t2_keep", 64'(down_keep), 64'h3);
    chk("t2_last", 64'(down_last), 64'h1);
    step(1, 8'hB0, 0, 1, 1); step(1, 8'hB1, 0, 1, 1);
    step(1, 8'hB2, 0, 1, 1); step(1, 8'hB3, 0, 1, 1);
    chk("t2_lane0", 64'(down_data), 64'hB3B2B1B0);

    // 3: stall five cycles with a byte offered
    held = down_data;
    for (int i = 0; i < 5; i++) begin
      step(1, 8'hEE, 0, 0, 1);
      chk("t3_stable", 64'(down_data), 64'(held));
    end
    step(0, 8'h00, 0, 1, 1);
    chk("t3_consumed", 64'(down_valid), 64'h0);

    // 4: back-to-back words
    for (int i = 1; i <= 8; i++) begin
      step(1, 8'(i), 0, 1, 1);
      if (i == 4) chk("t4_w0", 64'(down_data), 64'h04030201);
    end
    chk("t4_w1", 64'(down_data), 64'h08070605);

    // 5: last on the final lane
    step(1, 8'h51, 0, 1, 1); step(1, 8'h52, 0, 1, 1);
    step(1, 8'h53, 0, 1, 1); step(1, 8'h54, 1, 1, 1);
    chk("t5_keep", 64'(down_keep), 64'hF);
    chk("t5_last", 64'(down_last), 64'h1);
    step(1, 8'h60, 1, 1, 1);
    chk("t5_cnt0", 64'(down_data), 64'h00000060);

    // 6: reset mid-word
    step(1, 8'h71, 0, 1, 1); step(1, 8'h72, 0, 1, 1);
    step(1, 8'h73, 0, 1, 0);
    chk("t6_valid", 64'(down_valid), 64'h0);
    step(1, 8'hC1, 0, 1, 1); step(1, 8'hC2, 0, 1, 1);
    step(1, 8'hC3, 0, 1, 1); step(1, 8'hC4, 0, 1, 1);
    chk("t6_data", 64'(down_data), 64'hC4C3C2C1);
    chk("t6_keep", 64'(down_keep), 64'hF);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 4) == 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 99) != 0);
    end
    step(0, 8'h00, 0, 1, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
